// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit block memory port between the
// I-cache refill path and the D-cache refill/write-back path.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDR,
  output logic               I_BUSYWAIT,
  output logic [BLOCK_W-1:0] I_READDATA,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDR,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic               D_BUSYWAIT,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               M_READ,
  output logic               M_WRITE,
  output logic [ADDR_W-1:0]  M_ADDR,
  output logic [BLOCK_W-1:0] M_WRITEDATA,
  input  logic [BLOCK_W-1:0] M_READDATA,
  input  logic               M_BUSYWAIT,
  output logic               ERROR
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t             state_q, state_d;
  side_t              owner_q, owner_d;
  side_t              last_q, last_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
  logic               m_read_q, m_read_d;
  logic               m_write_q, m_write_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [BLOCK_W-1:0] m_wdata_q, m_wdata_d;

  logic i_req, d_req, pick_d;

  assign i_req  = I_READ;
  assign d_req  = D_READ | D_WRITE;
  // D wins when it is the only requester or when I was served last.
  assign pick_d = d_req & (~i_req | (last_q == SIDE_I));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          cnt_d = '0;
          if (pick_d) begin
            state_d   = GRANT_D;
            owner_d   = SIDE_D;
            last_d    = SIDE_D;
            m_addr_d  = D_ADDR;
            m_write_d = D_WRITE;
            m_read_d  = ~D_WRITE;
            m_wdata_d = D_WRITE ? D_WRITEDATA : '0;
          end else begin
            state_d   = GRANT_I;
            owner_d   = SIDE_I;
            last_d    = SIDE_I;
            m_addr_d  = I_ADDR;
            m_write_d = 1'b0;
            m_read_d  = 1'b1;
            m_wdata_d = '0;
          end
        end
      end

      GRANT_I, GRANT_D: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_MAX - 1'b1) error_d = 1'b1;
        // cnt_q == 0 marks the first grant cycle, where BUSYWAIT is not yet meaningful.
        if ((cnt_q != '0) && !M_BUSYWAIT) begin
          state_d   = DONE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (m_read_q) begin
            if (owner_q == SIDE_I) i_rdata_d = M_READDATA;
            else                   d_rdata_d = M_READDATA;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      owner_q   <= SIDE_D;
      last_q    <= SIDE_D;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign I_BUSYWAIT  = i_req & ~((state_q == DONE) && (owner_q == SIDE_I));
  assign D_BUSYWAIT  = d_req & ~((state_q == DONE) && (owner_q == SIDE_D));
  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;
  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDR      = m_addr_q;
  assign M_WRITEDATA = m_wdata_q;
  assign ERROR       = error_q;

endmodule
